// File: rtl/mac_accelerator.sv
// ---------------------------------------------------------------------------
// mac_accelerator
//
// Fixed-point multiply-accumulate stage for dense-layer neurons. Streams pairs
// of signed Q8.24 operands (activation x weight), seeds the Q24.24 accumulator
// with the neuron bias on the first beat, and on the last beat emits one Q8.24
// result after optional ReLU and saturation.
//
// Pipeline for a beat sampled at edge k:
//   k   : full-width product registered, first/last/valid tags, bias latched
//   k+1 : product rescaled to Q24.24 and accumulated (or seeds acc if first)
//   k+2 : on last beat, result registered and outValid pulses for one cycle
//
// Ports
//   clk        in   1       rising-edge clock
//   reset      in   1       synchronous, active-high
//   dataA      in   DATA_W  activation operand, Q8.24
//   dataB      in   DATA_W  weight operand, Q8.24
//   bias       in   DATA_W  neuron bias, Q8.24, sampled on first beat only
//   dataValid  in   1       beat qualifier
//   dataLast   in   1       final beat of a vector (only with dataValid)
//   dataOut    out  DATA_W  result, Q8.24, held until the next result
//   outValid   out  1       one-cycle pulse, dataOut valid
//   overflow   out  1       result saturated, updated with dataOut
//   busy       out  1       vector in progress or pipeline non-empty
// ---------------------------------------------------------------------------
module mac_accelerator #(
  parameter int DATA_W  = 32,
  parameter int FRAC_W  = 24,
  parameter int ACC_W   = 48,
  parameter int RELU_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] dataA,
  input  logic [DATA_W-1:0] dataB,
  input  logic [DATA_W-1:0] bias,
  input  logic              dataValid,
  input  logic              dataLast,
  output logic [DATA_W-1:0] dataOut,
  output logic              outValid,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_first;

  // Stage 1: product and tags
  logic signed [DATA_W-1:0]   w_a;
  logic signed [DATA_W-1:0]   w_b;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [2*DATA_W-1:0] r_p1_prod;
  logic                       r_p1_valid;
  logic                       r_p1_first;
  logic                       r_p1_last;
  logic [DATA_W-1:0]          r_p1_bias;

  // Stage 2: accumulator
  logic signed [ACC_W-1:0]    w_term;
  logic signed [ACC_W-1:0]    w_bias_ext;
  logic signed [ACC_W-1:0]    r_acc;
  logic                       r_p2_valid;
  logic                       r_p2_last;

  // Stage 3: result
  logic [DATA_W-1:0]          w_res;
  logic                       w_res_ovf;
  logic                       w_pos_ovf;
  logic                       w_neg_ovf;
  logic [DATA_W-1:0]          r_out;
  logic                       r_out_valid;
  logic                       r_ovf;

  // -------------------------------------------------------------------------
  // FSM: tracks whether a vector is open so the next beat knows if it is the
  // first one (and must re-seed the accumulator with the bias).
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of a combinational block gets a default first so that
  // no path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_first      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dataValid) begin
          w_first = 1'b1;
          // A first beat that is also last is a 1-beat vector: stay idle.
          if (!dataLast) begin
            w_state_next = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (dataValid && dataLast) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Stage 1: full-precision signed product. Size casts on signed operands
  // sign-extend, so the product is exact in 2*DATA_W bits.
  // -------------------------------------------------------------------------
  assign w_a    = dataA;
  assign w_b    = dataB;
  assign w_prod = (2*DATA_W)'(w_a) * (2*DATA_W)'(w_b);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p1_prod  <= '0;
      r_p1_valid <= 1'b0;
      r_p1_first <= 1'b0;
      r_p1_last  <= 1'b0;
      r_p1_bias  <= '0;
    end else begin
      r_p1_prod  <= w_prod;
      r_p1_valid <= dataValid;
      r_p1_first <= w_first;
      r_p1_last  <= dataValid & dataLast;
      if (w_first) begin
        r_p1_bias <= bias;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: rescale Q16.48 product to Q24.24 (arithmetic shift floors toward
  // -inf) and accumulate. The rescaled product fits in ACC_W bits for any
  // operand pair, so truncating the shifted value keeps its sign.
  // -------------------------------------------------------------------------
  assign w_term     = (ACC_W)'(r_p1_prod >>> FRAC_W);
  assign w_bias_ext = (ACC_W)'($signed(r_p1_bias));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_p2_valid <= 1'b0;
      r_p2_last  <= 1'b0;
    end else begin
      r_p2_valid <= r_p1_valid;
      r_p2_last  <= r_p1_last;
      // Bubbles leave the accumulator untouched, so gaps never affect results.
      if (r_p1_valid) begin
        r_acc <= r_p1_first ? (w_bias_ext + w_term) : (r_acc + w_term);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 3: ReLU then saturation to DATA_W. The accumulator fits in DATA_W
  // when all bits from the DATA_W-1 position upward equal the sign bit.
  // -------------------------------------------------------------------------
  assign w_pos_ovf = ~r_acc[ACC_W-1] &  (|r_acc[ACC_W-2:DATA_W-1]);
  assign w_neg_ovf =  r_acc[ACC_W-1] & ~(&r_acc[ACC_W-2:DATA_W-1]);

  always_comb begin
    w_res     = r_acc[DATA_W-1:0];
    w_res_ovf = 1'b0;
    if ((RELU_EN != 0) && r_acc[ACC_W-1]) begin
      w_res = '0;
    end else if (w_pos_ovf) begin
      w_res     = {1'b0, {(DATA_W-1){1'b1}}};
      w_res_ovf = 1'b1;
    end else if (w_neg_ovf) begin
      w_res     = {1'b1, {(DATA_W-1){1'b0}}};
      w_res_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_p2_last;
      if (r_p2_last) begin
        r_out <= w_res;
        r_ovf <= w_res_ovf;
      end
    end
  end

  assign dataOut  = r_out;
  assign overflow = r_ovf;
  assign outValid = r_out_valid;
  // The output pulse counts as the last pipe stage, so busy drops in the
  // cycle after outValid.
  assign busy     = (r_state == S_ACCUM) | r_p1_valid | r_p2_valid | r_out_valid;

endmodule
